// File: rtl/multi_ctrl_pkg.sv
// Shared types for the multi-control pipe blocks: lane count, lane mask and
// the arbiter burst-lock state.
package multi_ctrl_pkg;

  localparam int MC_LANE_N = 2;

  typedef logic [MC_LANE_N-1:0] mc_lane_mask_t;

  typedef enum logic {
    MC_ARB_OPEN,
    MC_ARB_LOCKED
  } mc_arb_lock_e;

endpackage

// File: rtl/mc_rr_arb.sv
// Combinational round-robin picker: first set request found searching upward
// from ptr_i (wrapping), returned as one-hot grant plus index.
module mc_rr_arb #(
  parameter int REQ_N = 4
) (
  input  logic [REQ_N-1:0]         req_i,
  input  logic [$clog2(REQ_N)-1:0] ptr_i,
  output logic [REQ_N-1:0]         gnt_o,
  output logic [$clog2(REQ_N)-1:0] idx_o,
  output logic                     vld_o
);

  localparam int IDX_W = $clog2(REQ_N);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < REQ_N; k++) begin
      pos = IDX_W'((32'(ptr_i) + k) % REQ_N);
      if (!vld_o && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_ctrl_mcast_arb.sv
// Round-robin arbiter feeding one 2-lane multicast pipe channel; holds each
// beat until every addressed lane handshakes. Optional MCAST_ARB_BURST_LOCK_EN.
module multi_ctrl_mcast_arb
  import multi_ctrl_pkg::*;
#(
  parameter int REQ_N  = 4,
  parameter int DATA_W = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REQ_N-1:0]           req_valid_in,
  input  logic [REQ_N*DATA_W-1:0]    req_data_in,
  input  logic [REQ_N*MC_LANE_N-1:0] req_dest_in,
`ifdef MCAST_ARB_BURST_LOCK_EN
  input  logic [REQ_N-1:0]           req_last_in,
`endif
  output logic [REQ_N-1:0]           req_ready_out,
  output logic [MC_LANE_N-1:0]       b_valid_out,
  output logic [DATA_W-1:0]          b_data_out,
  input  logic [MC_LANE_N-1:0]       b_ready_in,
  output logic [$clog2(REQ_N)-1:0]   grant_id_out
);

  localparam int IDX_W = $clog2(REQ_N);

  mc_lane_mask_t     pend_q, pend_d, drain, win_dest;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  gid_q, gid_d, rr_q, rr_d, win_idx, rr_next;
  logic [REQ_N-1:0]  elig, win_oh;
  logic              win_vld, free, capture;

  assign drain   = pend_q & b_ready_in;
  assign free    = (pend_q & ~drain) == '0;
  assign capture = free & win_vld;

`ifdef MCAST_ARB_BURST_LOCK_EN
  mc_arb_lock_e     lock_q, lock_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;

  assign elig = (lock_q == MC_ARB_LOCKED) ? (req_valid_in & (REQ_N'(1) << lock_id_q))
                                          : req_valid_in;
`else
  assign elig = req_valid_in;
`endif

  mc_rr_arb #(.REQ_N(REQ_N)) u_rr_arb (
    .req_i (elig),
    .ptr_i (rr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  assign req_ready_out = capture ? win_oh : '0;
  assign win_dest      = req_dest_in[win_idx*MC_LANE_N +: MC_LANE_N];
  assign rr_next       = (win_idx == IDX_W'(REQ_N-1)) ? '0 : win_idx + 1'b1;

  // Capture reloads pend outright: free guarantees nothing is left to merge.
  always_comb begin
    pend_d = pend_q & ~drain;
    data_d = data_q;
    gid_d  = gid_q;
    rr_d   = rr_q;
`ifdef MCAST_ARB_BURST_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
`endif
    if (capture) begin
      pend_d = win_dest;
      data_d = req_data_in[win_idx*DATA_W +: DATA_W];
      gid_d  = win_idx;
`ifdef MCAST_ARB_BURST_LOCK_EN
      if (req_last_in[win_idx]) begin
        lock_d = MC_ARB_OPEN;
        rr_d   = rr_next;
      end else begin
        lock_d    = MC_ARB_LOCKED;
        lock_id_d = win_idx;
      end
`else
      rr_d = rr_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
      rr_q   <= '0;
`ifdef MCAST_ARB_BURST_LOCK_EN
      lock_q    <= MC_ARB_OPEN;
      lock_id_q <= '0;
`endif
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      gid_q  <= gid_d;
      rr_q   <= rr_d;
`ifdef MCAST_ARB_BURST_LOCK_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  assign b_valid_out  = pend_q;
  assign b_data_out   = data_q;
  assign grant_id_out = gid_q;

endmodule

// File: tb/tb_multi_ctrl_mcast_arb.sv
// Bench for multi_ctrl_mcast_arb: directed scenarios then random traffic,
// checked against a distance-based round-robin reference model.
module tb_multi_ctrl_mcast_arb;

  localparam int REQ_N  = 4;
  localparam int DATA_W = 256;
  localparam int IDX_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [REQ_N-1:0]        req_valid_in;
  logic [REQ_N*DATA_W-1:0] req_data_in;
  logic [REQ_N*2-1:0]      req_dest_in;
  logic [REQ_N-1:0]        req_ready_out;
  logic [1:0]              b_valid_out;
  logic [DATA_W-1:0]       b_data_out;
  logic [1:0]              b_ready_in;
  logic [IDX_W-1:0]        grant_id_out;
`ifdef MCAST_ARB_BURST_LOCK_EN
  logic [REQ_N-1:0]        req_last_in;
  logic [REQ_N-1:0]        s_last;
`endif

  logic [REQ_N-1:0]  s_valid;
  logic [1:0]        s_dest [REQ_N];
  logic [DATA_W-1:0] s_beat [REQ_N];
  logic [1:0]        s_rdy;

  logic [1:0]        m_pend;
  logic [DATA_W-1:0] m_data;
  int                m_gid, m_rr, m_lock_id;
  bit                m_locked;

  int errors = 0;
  int checks = 0;

  multi_ctrl_mcast_arb #(.REQ_N(REQ_N), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_in  (req_valid_in),
    .req_data_in   (req_data_in),
    .req_dest_in   (req_dest_in),
`ifdef MCAST_ARB_BURST_LOCK_EN
    .req_last_in   (req_last_in),
`endif
    .req_ready_out (req_ready_out),
    .b_valid_out   (b_valid_out),
    .b_data_out    (b_data_out),
    .b_ready_in    (b_ready_in),
    .grant_id_out  (grant_id_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend    = 2'b00;
    m_data    = '0;
    m_gid     = 0;
    m_rr      = 0;
    m_locked  = 1'b0;
    m_lock_id = 0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < REQ_N; i++) begin
      req_data_in[i*DATA_W +: DATA_W] = s_beat[i];
      req_dest_in[i*2 +: 2]           = s_dest[i];
    end
    req_valid_in = s_valid;
    b_ready_in   = s_rdy;
`ifdef MCAST_ARB_BURST_LOCK_EN
    req_last_in  = s_last;
`endif
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance model, wait next edge.
  task automatic cycle();
    int               best, bestd, d;
    bit               free, lastbit;
    logic [REQ_N-1:0] exp_rdy;
    apply_inputs();
    #2;
    free  = (m_pend & ~s_rdy) == 2'b00;
    best  = -1;
    bestd = REQ_N;
    for (int i = 0; i < REQ_N; i++) begin
      if (s_valid[i] && (!m_locked || i == m_lock_id)) begin
        d = (i - m_rr + REQ_N) % REQ_N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    exp_rdy = (free && best >= 0) ? (REQ_N'(1) << best) : '0;
    chk("b_valid",   DATA_W'(b_valid_out),   DATA_W'(m_pend));
    chk("b_data",    b_data_out,             m_data);
    chk("grant_id",  DATA_W'(grant_id_out),  DATA_W'(m_gid));
    chk("req_ready", DATA_W'(req_ready_out), DATA_W'(exp_rdy));
    m_pend = m_pend & ~s_rdy;
    if (exp_rdy != '0) begin
      m_pend = s_dest[best];
      m_data = s_beat[best];
      m_gid  = best;
`ifdef MCAST_ARB_BURST_LOCK_EN
      lastbit = s_last[best];
`else
      lastbit = 1'b1;
`endif
      if (lastbit) begin
        m_locked = 1'b0;
        m_rr     = (best + 1) % REQ_N;
      end else begin
        m_locked  = 1'b1;
        m_lock_id = best;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat(input int i);
    for (int w = 0; w < DATA_W/32; w++) s_beat[i][w*32 +: 32] = $urandom;
  endtask

  initial begin
    s_valid = '0;
    s_rdy   = 2'b00;
    for (int i = 0; i < REQ_N; i++) begin
      s_dest[i] = 2'b00;
      s_beat[i] = '0;
    end
`ifdef MCAST_ARB_BURST_LOCK_EN
    s_last = '1;
`endif
    apply_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b_valid", DATA_W'(b_valid_out),   '0);
    chk("rst_b_data",  b_data_out,             '0);
    chk("rst_gid",     DATA_W'(grant_id_out),  '0);
    chk("rst_ready",   DATA_W'(req_ready_out), '0);
    rst_n = 1'b1;
    cycle();

    // Single request, both lanes ready: one beat visible for one cycle.
    s_valid = 4'b0001; s_dest[0] = 2'b11; s_beat[0] = DATA_W'(8'hA5); s_rdy = 2'b11;
    cycle();
    s_valid = '0;
    repeat (2) cycle();

    // Fairness on lane 0 with everybody requesting.
    for (int i = 0; i < REQ_N; i++) begin
      s_dest[i] = 2'b01;
      s_beat[i] = DATA_W'(32'h1000 + i);
    end
    s_valid = 4'b1111; s_rdy = 2'b01;
    repeat (9) cycle();
    s_valid = '0; s_rdy = 2'b11;
    cycle();

    // Lanes accepting in different cycles.
    s_valid = 4'b0010; s_dest[1] = 2'b11; s_dest[2] = 2'b11; s_rdy = 2'b00;
    rand_beat(1); rand_beat(2);
    cycle();
    s_valid = 4'b0110;
    s_rdy = 2'b01; cycle();
    s_rdy = 2'b00; cycle();
    cycle();
    s_rdy = 2'b10; cycle();
    s_rdy = 2'b11; s_valid = '0;
    repeat (2) cycle();

    // Zero destination mask: captured and dropped.
    s_valid = 4'b0100; s_dest[2] = 2'b00; s_dest[3] = 2'b01;
    cycle();
    s_valid = 4'b1101;
    repeat (2) cycle();
    s_valid = '0;
    repeat (2) cycle();

    // Async reset while lane 1 still pending.
    s_valid = 4'b0010; s_dest[1] = 2'b11; s_rdy = 2'b00; rand_beat(1);
    cycle();
    s_valid = '0; s_rdy = 2'b01;
    cycle();
    s_rdy = 2'b00;
    apply_inputs();
    chk("pre_rst_b_valid", DATA_W'(b_valid_out), DATA_W'(m_pend));
    rst_n = 1'b0;
    #1;
    chk("async_rst_b_valid", DATA_W'(b_valid_out),   '0);
    chk("async_rst_b_data",  b_data_out,             '0);
    chk("async_rst_gid",     DATA_W'(grant_id_out),  '0);
    chk("async_rst_ready",   DATA_W'(req_ready_out), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_valid = 4'b1111; s_rdy = 2'b11;
    for (int i = 0; i < REQ_N; i++) s_dest[i] = 2'b11;
    repeat (3) cycle();

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      s_valid = REQ_N'($urandom);
      s_rdy   = 2'($urandom);
      for (int i = 0; i < REQ_N; i++) begin
        s_dest[i] = 2'($urandom);
        if ($urandom_range(0, 3) == 0) rand_beat(i);
      end
`ifdef MCAST_ARB_BURST_LOCK_EN
      for (int i = 0; i < REQ_N; i++) s_last[i] = ($urandom_range(0, 2) != 0);
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
